demultiplex2_router: RTL and testbench

- Registered 1-to-3 demultiplexer with valid/ready handshaking on every channel; the write-side counterpart of the 3-way result multiplexer.
- Takes one source stream (e.g. execute-stage result) and steers each word to one of three destination channels (e.g. register file, memory, PC unit) selected per transfer.
- One-entry output register gives one-cycle latency at full throughput.
- Illegal selections are absorbed and counted; they are never delivered.

---
 rtl/demultiplex2_router.sv | 106 ++++++++++
 tb/tb_demultiplex2_router.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplex2_router.sv
// Registered 1-to-3 demultiplexer with valid/ready handshaking on every channel.
// Illegal selections are consumed, never delivered, and tallied in a saturating counter.
module demultiplex2_router #(
  parameter int unsigned data_size  = 32,
  parameter int unsigned count_size = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [1:0]            selection_in,
  input  logic [data_size-1:0]  data_in,
  output logic                  valid_out1,
  input  logic                  ready_in1,
  output logic [data_size-1:0]  data_out1,
  output logic                  valid_out2,
  input  logic                  ready_in2,
  output logic [data_size-1:0]  data_out2,
  output logic                  valid_out3,
  input  logic                  ready_in3,
  output logic [data_size-1:0]  data_out3,
  output logic                  error_out,
  output logic [count_size-1:0] drop_count_out
);

  localparam logic [1:0] DestCh1     = 2'b00;
  localparam logic [1:0] DestCh2     = 2'b01;
  localparam logic [1:0] DestCh3     = 2'b10;
  localparam logic [1:0] DestIllegal = 2'b11;

  logic [data_size-1:0]  hold_data_q, hold_data_d;
  logic [1:0]            hold_dest_q, hold_dest_d;
  logic                  full_q, full_d;
  logic                  error_q, error_d;
  logic [count_size-1:0] drop_count_q, drop_count_d;

  logic sel_ready;
  logic drain;
  logic accept;
  logic legal;

  // Only the ready of the channel currently holding the word matters.
  always_comb begin
    sel_ready = 1'b0;
    unique case (hold_dest_q)
      DestCh1: sel_ready = ready_in1;
      DestCh2: sel_ready = ready_in2;
      DestCh3: sel_ready = ready_in3;
      default: sel_ready = 1'b0;
    endcase
  end

  assign drain     = full_q && sel_ready;
  assign ready_out = !full_q || drain;
  assign accept    = valid_in && ready_out;
  assign legal     = (selection_in != DestIllegal);

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_dest_d  = hold_dest_q;
    full_d       = full_q;
    error_d      = error_q;
    drop_count_d = drop_count_q;

    if (drain) begin
      full_d = 1'b0;
    end

    if (accept && legal) begin
      hold_data_d = data_in;
      hold_dest_d = selection_in;
      full_d      = 1'b1;
    end else if (accept) begin
      error_d = 1'b1;
      if (drop_count_q != {count_size{1'b1}}) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hold_data_q  <= '0;
      hold_dest_q  <= DestCh1;
      full_q       <= 1'b0;
      error_q      <= 1'b0;
      drop_count_q <= '0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_dest_q  <= hold_dest_d;
      full_q       <= full_d;
      error_q      <= error_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign valid_out1     = full_q && (hold_dest_q == DestCh1);
  assign valid_out2     = full_q && (hold_dest_q == DestCh2);
  assign valid_out3     = full_q && (hold_dest_q == DestCh3);
  assign data_out1      = hold_data_q;
  assign data_out2      = hold_data_q;
  assign data_out3      = hold_data_q;
  assign error_out      = error_q;
  assign drop_count_out = drop_count_q;

endmodule

// File: tb/tb_demultiplex2_router.sv
// Directed self-checking bench for demultiplex2_router: routing, back-pressure,
// illegal-selection drops with saturation, and asynchronous reset.
module tb_demultiplex2_router;

  localparam int unsigned DataSize  = 32;
  localparam int unsigned CountSize = 8;

  logic                 clock_in = 1'b0;
  logic                 reset_n_in;
  logic                 valid_in;
  logic                 ready_out;
  logic [1:0]           selection_in;
  logic [DataSize-1:0]  data_in;
  logic                 valid_out1, valid_out2, valid_out3;
  logic                 ready_in1, ready_in2, ready_in3;
  logic [DataSize-1:0]  data_out1, data_out2, data_out3;
  logic                 error_out;
  logic [CountSize-1:0] drop_count_out;

  int checks = 0;
  int fails  = 0;

  demultiplex2_router #(
    .data_size (DataSize),
    .count_size(CountSize)
  ) dut (
    .clock_in      (clock_in),
    .reset_n_in    (reset_n_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .selection_in  (selection_in),
    .data_in       (data_in),
    .valid_out1    (valid_out1),
    .ready_in1     (ready_in1),
    .data_out1     (data_out1),
    .valid_out2    (valid_out2),
    .ready_in2     (ready_in2),
    .data_out2     (data_out2),
    .valid_out3    (valid_out3),
    .ready_in3     (ready_in3),
    .data_out3     (data_out3),
    .error_out     (error_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clock_in);
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [DataSize-1:0] d);
    valid_in     = v;
    selection_in = sel;
    data_in      = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_v1"}, 64'(valid_out1), 64'd0);
    check_eq({tag, "_v2"}, 64'(valid_out2), 64'd0);
    check_eq({tag, "_v3"}, 64'(valid_out3), 64'd0);
    check_eq({tag, "_d1"}, 64'(data_out1), 64'd0);
    check_eq({tag, "_err"}, 64'(error_out), 64'd0);
    check_eq({tag, "_cnt"}, 64'(drop_count_out), 64'd0);
  endtask

  initial begin
    int exp_cnt;
    logic any_valid;

    reset_n_in = 1'b0;
    drive(1'b0, 2'b00, '0);
    ready_in1 = 1'b1;
    ready_in2 = 1'b1;
    ready_in3 = 1'b1;
    repeat (2) @(posedge clock_in);
    sample();
    check_all_zero("reset");
    check_eq("reset_ready", 64'(ready_out), 64'd1);
    tick();
    reset_n_in = 1'b1;

    // Single transfer to ch2
    drive(1'b1, 2'b01, 32'hDEAD_BEEF);
    sample();
    check_eq("t1_ready", 64'(ready_out), 64'd1);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("t1_v2", 64'(valid_out2), 64'd1);
    check_eq("t1_d2", 64'(data_out2), 64'hDEAD_BEEF);
    check_eq("t1_v1", 64'(valid_out1), 64'd0);
    check_eq("t1_v3", 64'(valid_out3), 64'd0);
    tick();
    sample();
    check_eq("t1_cleared", 64'(valid_out2), 64'd0);
    tick();

    // Back-to-back stream with alternating destinations
    drive(1'b1, 2'b00, 32'h1);
    sample();
    check_eq("s_ready0", 64'(ready_out), 64'd1);
    tick();
    drive(1'b1, 2'b10, 32'h2);
    sample();
    check_eq("s_v1", 64'(valid_out1), 64'd1);
    check_eq("s_d1", 64'(data_out1), 64'h1);
    check_eq("s_ready1", 64'(ready_out), 64'd1);
    tick();
    drive(1'b1, 2'b01, 32'h3);
    sample();
    check_eq("s_v3", 64'(valid_out3), 64'd1);
    check_eq("s_d3", 64'(data_out3), 64'h2);
    check_eq("s_v1_off", 64'(valid_out1), 64'd0);
    check_eq("s_ready2", 64'(ready_out), 64'd1);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("s_v2", 64'(valid_out2), 64'd1);
    check_eq("s_d2", 64'(data_out2), 64'h3);
    check_eq("s_v3_off", 64'(valid_out3), 64'd0);
    tick();
    sample();
    check_eq("s_idle", 64'({valid_out1, valid_out2, valid_out3}), 64'd0);
    tick();

    // Back-pressure on ch3 while the source offers a ch1 word
    ready_in3 = 1'b0;
    drive(1'b1, 2'b10, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 2'b00, 32'h5);
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("bp_v3", 64'(valid_out3), 64'd1);
      check_eq("bp_d3", 64'(data_out3), 64'hA5A5_A5A5);
      check_eq("bp_ready", 64'(ready_out), 64'd0);
      check_eq("bp_v1", 64'(valid_out1), 64'd0);
      tick();
    end
    ready_in3 = 1'b1;
    sample();
    check_eq("bp_release_ready", 64'(ready_out), 64'd1);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("bp_v1_after", 64'(valid_out1), 64'd1);
    check_eq("bp_d1_after", 64'(data_out1), 64'h5);
    check_eq("bp_v3_after", 64'(valid_out3), 64'd0);
    tick();

    // Illegal word offered while ch2 is stalled
    ready_in2 = 1'b0;
    drive(1'b1, 2'b01, 32'h77);
    tick();
    drive(1'b1, 2'b11, 32'h99);
    sample();
    check_eq("ds_ready", 64'(ready_out), 64'd0);
    tick();
    sample();
    check_eq("ds_cnt_hold", 64'(drop_count_out), 64'd0);
    check_eq("ds_err_hold", 64'(error_out), 64'd0);
    check_eq("ds_v2_hold", 64'(valid_out2), 64'd1);
    ready_in2 = 1'b1;
    #1;
    check_eq("ds_ready_drain", 64'(ready_out), 64'd1);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("ds_cnt", 64'(drop_count_out), 64'd1);
    check_eq("ds_err", 64'(error_out), 64'd1);
    check_eq("ds_full_clr", 64'({valid_out1, valid_out2, valid_out3}), 64'd0);
    check_eq("ds_ready_idle", 64'(ready_out), 64'd1);
    tick();

    // 300 illegal words: counter saturates, nothing delivered
    exp_cnt   = 1;
    any_valid = 1'b0;
    drive(1'b1, 2'b11, 32'hBAD);
    for (int i = 0; i < 300; i++) begin
      data_in = DataSize'(i);
      tick();
      sample();
      if (exp_cnt < 255) exp_cnt++;
      check_eq("sat_cnt", 64'(drop_count_out), 64'(exp_cnt));
      any_valid = any_valid | valid_out1 | valid_out2 | valid_out3;
    end
    drive(1'b0, 2'b00, '0);
    check_eq("sat_no_valid", 64'(any_valid), 64'd0);
    check_eq("sat_final", 64'(drop_count_out), 64'd255);
    check_eq("sat_err", 64'(error_out), 64'd1);
    tick();

    // Asynchronous reset with a stalled ch1 word and error set
    ready_in1 = 1'b0;
    drive(1'b1, 2'b00, 32'h1234);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("ar_pre_v1", 64'(valid_out1), 64'd1);
    check_eq("ar_pre_err", 64'(error_out), 64'd1);
    #2;
    reset_n_in = 1'b0;
    #1;
    check_all_zero("ar");
    #1;
    reset_n_in = 1'b1;
    ready_in1 = 1'b1;
    tick();
    drive(1'b1, 2'b10, 32'hCAFE);
    tick();
    drive(1'b0, 2'b00, '0);
    sample();
    check_eq("ar_post_v3", 64'(valid_out3), 64'd1);
    check_eq("ar_post_d3", 64'(data_out3), 64'hCAFE);
    check_eq("ar_post_v1", 64'(valid_out1), 64'd0);
    check_eq("ar_post_cnt", 64'(drop_count_out), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
